shift_rx_deframer: RTL and testbench

SHIFT_RX_DEFRAMER -- requirements
Module: shift_rx_deframer

---
 rtl/shift_rx_deframer.sv | 112 +++++++++++
 tb/tb_shift_rx_deframer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rx_deframer.sv
// Serial frame deframer: start bit, WIDTH data bits (LSB- or MSB-first), optional even parity,
// delivered through a valid/ready output register with sticky overrun. Parity: `define DESER_PARITY_EN.
module shift_rx_deframer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             serial_in,
   input  logic             lsb_first,
   input  logic             out_ready,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             parity_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    pos;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             lsb_q;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, perr_q, perr_d, ovr_q;
   logic             complete;

   // NOTE: every signal gets a default before any conditional assignment so no latch is inferred.
   always_comb begin
      pos      = lsb_q ? cnt_q : (LAST - cnt_q);
      shift_d  = shift_q;
      shift_d[pos] = serial_in;
      complete = 1'b0;
      perr_d   = 1'b0;
      word_d   = shift_d;
`ifdef DESER_PARITY_EN
      // The word is already fully assembled when the parity bit arrives.
      complete = enable && (state_q == PAR);
      perr_d   = (^shift_q) ^ serial_in;
      word_d   = shift_q;
`else
      complete = enable && (state_q == DATA) && (cnt_q == LAST);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         lsb_q   <= 1'b0;
         word_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (enable) begin
            case (state_q)
               IDLE: begin
                  if (serial_in) begin
                     state_q <= DATA;
                     cnt_q   <= '0;
                     lsb_q   <= lsb_first;
                  end
               end
               DATA: begin
                  shift_q <= shift_d;
                  cnt_q   <= cnt_q + CW'(1);
                  if (cnt_q == LAST) begin
`ifdef DESER_PARITY_EN
                     state_q <= PAR;
`else
                     state_q <= IDLE;
`endif
                  end
               end
`ifdef DESER_PARITY_EN
               PAR:     state_q <= IDLE;
`endif
               default: state_q <= IDLE;
            endcase
         end

         // A completed word loads if the register is empty or being emptied this cycle.
         if (complete && (!valid_q || out_ready)) begin
            word_q  <= word_d;
            perr_q  <= perr_d;
            valid_q <= 1'b1;
         end else begin
            if (complete) ovr_q <= 1'b1;
            if (valid_q && out_ready) valid_q <= 1'b0;
         end
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_rx_deframer.sv
// Randomized and directed bench for shift_rx_deframer; a bit-list model predicts every output each cycle.
module tb_shift_rx_deframer;

   localparam int W = 16;
`ifdef DESER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         serial_in = 1'b0;
   logic         lsb_first = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] word_out;
   logic         word_valid, parity_err, overrun, busy;

   int checks = 0;
   int errors = 0;

   shift_rx_deframer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .serial_in  (serial_in),
      .lsb_first  (lsb_first),
      .out_ready  (out_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collect strobed bits after a start bit, build the word once NB bits are in.
   logic         m_in_frame = 1'b0;
   logic         m_lsb = 1'b0;
   logic         m_bits[$];
   logic [W-1:0] m_word = '0;
   logic         m_valid = 1'b0, m_perr = 1'b0, m_ovr = 1'b0;

   always @(posedge clk) begin : model
      logic         xfer, done, pe;
      logic [W-1:0] w;
      xfer = 1'b0; done = 1'b0; pe = 1'b0; w = '0;
      if (rst) begin
         m_in_frame = 1'b0;
         m_bits.delete();
         m_word = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
      end else begin
         xfer = m_valid && out_ready;
         if (enable) begin
            if (!m_in_frame) begin
               if (serial_in) begin
                  m_in_frame = 1'b1;
                  m_lsb = lsb_first;
                  m_bits.delete();
               end
            end else begin
               m_bits.push_back(serial_in);
               if (m_bits.size() == NB) begin
                  for (int i = 0; i < W; i++) w[m_lsb ? i : W-1-i] = m_bits[i];
`ifdef DESER_PARITY_EN
                  pe = (^w) ^ m_bits[W];
`endif
                  done = 1'b1;
                  m_in_frame = 1'b0;
               end
            end
         end
         if (done) begin
            if (!m_valid || xfer) begin
               m_word = w; m_perr = pe; m_valid = 1'b1;
            end else m_ovr = 1'b1;
         end else if (xfer) m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin : compare
      if (!rst) begin
         check("valid", {31'd0, word_valid}, {31'd0, m_valid});
         check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
         check("busy", {31'd0, busy}, {31'd0, m_in_frame});
         if (m_valid) begin
            check("word", 32'(word_out), 32'(m_word));
            check("perr", {31'd0, parity_err}, {31'd0, m_perr});
         end
      end
   end

   task automatic strobe(input logic b, input int gap, input bit rnd_rdy, input logic lsbv);
      for (int i = 1; i < gap; i++) begin
         @(negedge clk);
         enable = 1'b0;
         serial_in = 1'($urandom);
         lsb_first = 1'($urandom);
         if (rnd_rdy) out_ready = 1'($urandom);
      end
      @(negedge clk);
      enable = 1'b1;
      serial_in = b;
      lsb_first = lsbv;
      if (rnd_rdy) out_ready = 1'($urandom);
   endtask

   // Data strobes drive the opposite lsb_first to show the frame keeps its latched order.
   task automatic send_frame(input logic [W-1:0] w, input logic lsb, input int gap,
                             input logic bad_par, input bit rnd_rdy, input bit rdy_last);
      strobe(1'b1, gap, rnd_rdy, lsb);
      for (int i = 0; i < W; i++) strobe(lsb ? w[i] : w[W-1-i], gap, rnd_rdy, ~lsb);
`ifdef DESER_PARITY_EN
      strobe((^w) ^ bad_par, gap, rnd_rdy, ~lsb);
`else
      if (bad_par) lsb_first = ~lsb;
`endif
      if (rdy_last) out_ready = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         enable = 1'b0;
      end
   endtask

   task automatic drain;
      @(negedge clk);
      enable = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, word_valid}, 32'd0);
      check("rst_word", 32'(word_out), 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ovr", {31'd0, overrun}, 32'd0);
      rst = 1'b0;

      // LSB-first, enable every cycle, latency of one clock.
      send_frame(16'hA5C3, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      check("a5c3_pre_valid", {31'd0, word_valid}, 32'd0);
      idle(1);
      check("a5c3_valid", {31'd0, word_valid}, 32'd1);
      check("a5c3_word", 32'(word_out), 32'h0000A5C3);
      check("a5c3_perr", {31'd0, parity_err}, 32'd0);
      drain();
      check("a5c3_drained", {31'd0, word_valid}, 32'd0);

      // MSB-first, strobe every third cycle.
      send_frame(16'h1234, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("1234_word", 32'(word_out), 32'h00001234);
      drain();

`ifdef DESER_PARITY_EN
      send_frame(16'h0001, 1'b1, 1, 1'b1, 1'b0, 1'b0);
      idle(1);
      check("par_word", 32'(word_out), 32'h00000001);
      check("par_err", {31'd0, parity_err}, 32'd1);
      check("par_valid", {31'd0, word_valid}, 32'd1);
      drain();
`endif

      // Overrun: second back-to-back frame completes while the first is held.
      send_frame(16'h00FF, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      send_frame(16'hFF00, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("ovr_word", 32'(word_out), 32'h000000FF);
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      drain();
      check("ovr_after_valid", {31'd0, word_valid}, 32'd0);
      check("ovr_sticky", {31'd0, overrun}, 32'd1);

      // Mid-frame reset held two cycles with enable and out_ready high.
      strobe(1'b1, 1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) strobe(1'($urandom), 1, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1; enable = 1'b1; serial_in = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; enable = 1'b0; out_ready = 1'b0;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
      check("mid_rst_valid", {31'd0, word_valid}, 32'd0);
      check("mid_rst_word", 32'(word_out), 32'd0);
      check("mid_rst_perr", {31'd0, parity_err}, 32'd0);
      send_frame(16'h5A3C, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("post_rst_word", 32'(word_out), 32'h00005A3C);
      drain();

      // Transfer on the same cycle the next word completes.
      send_frame(16'h1111, 1'b0, 1, 1'b0, 1'b0, 1'b0);
      send_frame(16'h2222, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      enable = 1'b0; out_ready = 1'b0;
      check("swap_word", 32'(word_out), 32'h00002222);
      check("swap_valid", {31'd0, word_valid}, 32'd1);
      check("swap_ovr", {31'd0, overrun}, 32'd0);
      drain();

      for (int f = 0; f < 60; f++) begin
         send_frame(W'($urandom), 1'($urandom), int'($urandom_range(1, 3)),
                    ($urandom_range(0, 3) == 0), 1'b1, 1'b0);
         idle(int'($urandom_range(0, 2)));
      end
      out_ready = 1'b1;
      idle(4);
      check("final_valid", {31'd0, word_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
